adder_share_arbiter: RTL and testbench
======================================

# adder_share_arbiter

Round-robin arbiter and sequencer that shares one N-bit `adder` instance among NREQ requesters. Each requester presents an operand pair under a valid/ready handshake. Granted operands pass through the shared combinational adder into a single-entry result register, tagged with the requester ID. Utilisation counters support energy/activity characterisation of the shared adder under different injection rates.

## Interface
- `N`, 23: operand and sum width in bits.
- `NREQ`, 4: number of requesters (2..16).
- `ID_W`, $clog2(NREQ): width of the requester ID.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req_valid`  in  NREQ  bit k: requester k presents operands.
- `req_ready`  out  NREQ  bit k: requester k granted this cycle (one-hot or zero).
- `req_a`  in  NREQ*N  operand A; requester k occupies bits [k*N +: N].
- `req_b`  in  NREQ*N  operand B; same packing as `req_a`.
- `res_valid`  out  1  result register holds a valid sum.
- `res_ready`  in  1  consumer accepts the result.
- `res_sum`  out  N  (A+B) mod 2^N.
- `res_id`  out  ID_W  index of the requester that produced `res_sum`.
- `cnt_busy`  out  32  cycles in which a grant occurred.
- `cnt_total`  out  32  cycles since reset.

## Operation
- Output slot:
  - `can_accept` = !res_valid | res_ready.
  - The adder is used only when `can_accept` and at least one `req_valid` is set.
- Arbitration:
  - Round-robin pointer `ptr` (ID_W bits). Search starts at `ptr` and proceeds through ptr+1, … wrapping modulo NREQ.
  - The first k with req_valid[k]=1 is granted: req_ready[k]=1, all other ready bits 0.
  - After a grant to k, ptr ← (k+1) mod NREQ.
  - With no grant, ptr holds its value.
- Datapath:
  - A one-hot mux drives req_a/req_b of the granted k into the shared `adder`.
  - On grant: res_sum ← sum, res_id ← k, res_valid ← 1.
  - If not granting and res_ready=1: res_valid ← 0.
  - Carry-out is discarded; the sum wraps modulo 2^N.
- Handshake:
  - A request is consumed in the cycle where req_valid[k] & req_ready[k].
  - Requesters hold their operands stable until consumed.
  - req_ready depends combinationally on req_valid and res_ready; no requester-side input may depend combinationally on req_ready.
- Counters:
  - `cnt_total` increments every non-reset cycle.
  - `cnt_busy` increments on each grant.
  - Both saturate at 2^32−1 and do not wrap.
- Reset values:
  - res_valid=0, res_sum=0, res_id=0, ptr=0, cnt_busy=0, cnt_total=0.
  - req_ready=0 while rst=1.
  - A reset mid-transfer discards the held result; no grant is issued in the reset cycle.

## Timing
- Latency: a grant in cycle t gives res_valid=1 with that sum in cycle t+1.
- Throughput: one result per cycle with res_ready held at 1; no bubble between back-to-back grants.
- Backpressure: while res_valid & !res_ready:
  - all req_ready=0;
  - res_sum, res_id and ptr are held unchanged.
- Simultaneous drain and grant in one cycle: the register is overwritten with the new result and res_valid stays 1.
- Single active requester: it is granted every cycle regardless of ptr.
- Pointer wrap: a grant to k=NREQ−1 sets ptr to 0.

## Structure
- Shared package `adder_pkg`:
  - default `N` and `NREQ`;
  - `ID_W` derivation;
  - round-robin helper function `rr_pick(valid, ptr)` returning the grant index and a found flag.
- One sub-module: the existing combinational `adder` (ports input1, input2, sum), instantiated once.
- The mux, pointer, result register and counters stay in this block.

## Test plan
- Reset, then req_valid=4'b0000 for 10 cycles → res_valid=0, req_ready=0, cnt_total=10, cnt_busy=0.
- Single request: req 2 with a=23'h000001, b=23'h7FFFFF → req_ready=4'b0100 in that cycle; next cycle res_sum=23'h000000 (wrap), res_id=2.
- All four valid continuously, res_ready=1 → grant order 0,1,2,3,0,…; one result per cycle; after 8 cycles cnt_busy=8.
- Backpressure: res_ready=0 for 3 cycles while all four requests are valid → req_ready=0; res_sum/res_id frozen; on res_ready=1 the next grant follows ptr.
- Walking thermometer operands: a=23'h7F0000/b=23'h00FFFF style patterns on req 0 with a 7-cycle idle gap every 20 flits, 10 packets → every res_sum equals (a+b) mod 2^23; cnt_busy=200.
- Assert rst in the cycle after a grant → res_valid=0 and ptr=0 in the following cycle; the discarded result never appears.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults, ID width derivation and the round-robin pick helper
// used by the shared-adder arbiter.
package adder_pkg;

  localparam int unsigned DEF_N    = 23;
  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned MAX_NREQ = 16;
  localparam int unsigned MAX_ID_W = 4;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned id_w(input int unsigned nreq);
    return $clog2(nreq);
  endfunction

  // First valid index at or after ptr, wrapping modulo nreq.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                       input logic [MAX_ID_W-1:0] ptr,
                                       input int unsigned         nreq = DEF_NREQ);
    rr_pick_t            r;
    int unsigned         pos;
    logic [MAX_ID_W-1:0] slot;
    r = '0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if (i < nreq && !r.found) begin
        pos  = (32'(ptr) + i) % nreq;
        slot = MAX_ID_W'(pos);
        if (valid[slot]) begin
          r.found = 1'b1;
          r.idx   = slot;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester/result bus of the shared-adder arbiter, plus activity counters.
interface adder_share_arbiter_if
  import adder_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned NREQ = DEF_NREQ
);
  localparam int unsigned ID_W = id_w(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [N-1:0]      res_sum;
  logic [ID_W-1:0]   res_id;
  logic [31:0]       cnt_busy;
  logic [31:0]       cnt_total;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_id, cnt_busy, cnt_total
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_id, cnt_busy, cnt_total
  );

endinterface

// File: rtl/adder.sv
// Shared combinational N-bit adder; carry-out is dropped.
module adder #(
  parameter int unsigned N = adder_pkg::DEF_N
) (
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic [N-1:0] sum
);

  assign sum = input1 + input2;

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one adder among NREQ requesters, with a single-entry
// tagged result register and saturating busy/total cycle counters.
module adder_share_arbiter
  import adder_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned NREQ = DEF_NREQ
) (
  input logic                  clk,
  input logic                  rst,
  adder_share_arbiter_if.slave bus
);

  localparam int unsigned ID_W    = id_w(NREQ);
  localparam logic [31:0] CNT_MAX = '1;

  rr_pick_t        pick_c;
  logic            can_accept_c;
  logic            grant_c;
  logic [ID_W-1:0] gnt_idx_c;
  logic [NREQ-1:0] req_ready_c;
  logic [N-1:0]    op_a_c;
  logic [N-1:0]    op_b_c;
  logic [N-1:0]    sum_c;
  logic            unused_pick_c;

  logic            res_valid_q, res_valid_d;
  logic [N-1:0]    res_sum_q,   res_sum_d;
  logic [ID_W-1:0] res_id_q,    res_id_d;
  logic [ID_W-1:0] ptr_q,       ptr_d;
  logic [31:0]     cnt_busy_q,  cnt_busy_d;
  logic [31:0]     cnt_total_q, cnt_total_d;

  // Grant only when the result slot is free or draining this cycle.
  always_comb begin
    can_accept_c = !res_valid_q || bus.res_ready;
    pick_c       = rr_pick(MAX_NREQ'(bus.req_valid), MAX_ID_W'(ptr_q), NREQ);
    grant_c      = can_accept_c && pick_c.found && !rst;
    gnt_idx_c    = ID_W'(pick_c.idx);
    req_ready_c  = '0;
    if (grant_c) begin
      req_ready_c[gnt_idx_c] = 1'b1;
    end
  end

  assign unused_pick_c = ^pick_c.idx;

  always_comb begin
    op_a_c = '0;
    op_b_c = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (req_ready_c[k]) begin
        op_a_c |= bus.req_a[k*N +: N];
        op_b_c |= bus.req_b[k*N +: N];
      end
    end
  end

  adder #(.N(N)) u_adder (
    .input1 (op_a_c),
    .input2 (op_b_c),
    .sum    (sum_c)
  );

  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    ptr_d       = ptr_q;
    cnt_busy_d  = cnt_busy_q;
    cnt_total_d = cnt_total_q;

    if (cnt_total_q != CNT_MAX) begin
      cnt_total_d = cnt_total_q + 32'd1;
    end

    if (grant_c) begin
      res_valid_d = 1'b1;
      res_sum_d   = sum_c;
      res_id_d    = gnt_idx_c;
      ptr_d       = (gnt_idx_c == ID_W'(NREQ - 1)) ? '0 : gnt_idx_c + ID_W'(1);
      if (cnt_busy_q != CNT_MAX) begin
        cnt_busy_d = cnt_busy_q + 32'd1;
      end
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
      ptr_q       <= '0;
      cnt_busy_q  <= '0;
      cnt_total_q <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      ptr_q       <= ptr_d;
      cnt_busy_q  <= cnt_busy_d;
      cnt_total_q <= cnt_total_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_id    = res_id_q;
  assign bus.cnt_busy  = cnt_busy_q;
  assign bus.cnt_total = cnt_total_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed scenarios plus random traffic,
// compared every cycle against a behavioural round-robin model.
module tb_adder_share_arbiter;
  import adder_pkg::*;

  localparam int unsigned N    = 23;
  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  adder_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [NREQ-1:0] valid_r     = '0;
  logic            res_ready_r = 1'b1;
  logic [N-1:0]    a_r [NREQ];
  logic [N-1:0]    b_r [NREQ];

  always_comb begin
    bus.req_valid = valid_r;
    bus.res_ready = res_ready_r;
    for (int k = 0; k < NREQ; k++) begin
      bus.req_a[k*N +: N] = a_r[k];
      bus.req_b[k*N +: N] = b_r[k];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Behavioural model: state as the spec describes it, advanced once per cycle.
  bit           m_rv    = 1'b0;
  bit [N-1:0]   m_sum   = '0;
  int           m_id    = 0;
  int           m_ptr   = 0;
  longint       m_busy  = 0;
  longint       m_total = 0;
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  always @(negedge clk) begin : model_cmp
    int              g;
    int              k;
    logic [NREQ-1:0] exp_ready;
    g = -1;
    if (!rst && (!m_rv || res_ready_r)) begin
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (g < 0 && valid_r[k]) g = k;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;

    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("res_valid", 64'(bus.res_valid), 64'(m_rv));
    chk("res_sum",   64'(bus.res_sum),   64'(m_sum));
    chk("res_id",    64'(bus.res_id),    64'(m_id));
    chk("cnt_busy",  64'(bus.cnt_busy),  64'(m_busy));
    chk("cnt_total", 64'(bus.cnt_total), 64'(m_total));

    if (rst) begin
      m_rv = 1'b0; m_sum = '0; m_id = 0; m_ptr = 0; m_busy = 0; m_total = 0;
    end else begin
      if (m_total < CMAX) m_total++;
      if (g >= 0) begin
        m_rv  = 1'b1;
        m_sum = a_r[g] + b_r[g];
        m_id  = g;
        m_ptr = (g + 1) % NREQ;
        if (m_busy < CMAX) m_busy++;
      end else if (res_ready_r) begin
        m_rv = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst     = 1'b1;
    valid_r = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin : main
    logic [N-1:0]    s3;
    logic [NREQ-1:0] cons;
    logic [NREQ-1:0] one_hot;
    int              idx;
    int              rate;

    for (int k = 0; k < NREQ; k++) begin
      a_r[k] = '0;
      b_r[k] = '0;
    end
    repeat (3) step();
    rst = 1'b0;

    // Idle after reset
    repeat (10) step();
    @(negedge clk);
    chk("idle_total",     64'(bus.cnt_total), 64'd10);
    chk("idle_busy",      64'(bus.cnt_busy),  64'd0);
    chk("idle_res_valid", 64'(bus.res_valid), 64'd0);
    chk("idle_ready",     64'(bus.req_ready), 64'd0);
    chk("model_total10",  64'(m_total),       64'd10);

    // Single request with wrapping sum
    step();
    a_r[2]  = 23'h000001;
    b_r[2]  = 23'h7FFFFF;
    valid_r = 4'b0100;
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready), 64'(4'b0100));
    step();
    valid_r = '0;
    chk("single_sum",   64'(bus.res_sum),   64'h0);
    chk("single_id",    64'(bus.res_id),    64'd2);
    chk("single_valid", 64'(bus.res_valid), 64'd1);

    // All four valid: strict 0,1,2,3 rotation
    step();
    reset_pulse();
    for (int k = 0; k < NREQ; k++) begin
      a_r[k] = N'(32'h1000 * (k + 1) + 32'h7);
      b_r[k] = N'(32'h30 * (k + 3));
    end
    s3          = a_r[3] + b_r[3];
    valid_r     = 4'hF;
    res_ready_r = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      one_hot = '0;
      one_hot[i % 4] = 1'b1;
      chk("rr_order", 64'(bus.req_ready), 64'(one_hot));
      step();
    end
    res_ready_r = 1'b0;
    chk("rr_busy8",  64'(bus.cnt_busy), 64'd8);
    chk("model_busy8", 64'(m_busy),     64'd8);

    // Backpressure freezes the result and blocks grants
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bp_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_id",    64'(bus.res_id),    64'd3);
      chk("bp_sum",   64'(bus.res_sum),   64'(s3));
      step();
    end
    res_ready_r = 1'b1;
    @(negedge clk);
    chk("bp_resume", 64'(bus.req_ready), 64'(4'b0001));

    // Thermometer operands on requester 0, 10 packets of 20 flits
    step();
    reset_pulse();
    for (int p = 0; p < 10; p++) begin
      for (int f = 0; f < 20; f++) begin
        idx = p * 20 + f;
        if (idx == 0) begin
          a_r[0] = 23'h7F0000;
          b_r[0] = 23'h00FFFF;
        end else begin
          a_r[0] = N'(23'h7FFFFF << (idx % 23));
          b_r[0] = N'(23'h7FFFFF >> ((idx * 3) % 23));
        end
        valid_r = 4'b0001;
        step();
        if (idx == 0) chk("therm_first", 64'(bus.res_sum), 64'h7FFFFF);
      end
      valid_r = '0;
      repeat (7) step();
    end
    chk("therm_busy",       64'(bus.cnt_busy), 64'd200);
    chk("model_therm_busy", 64'(m_busy),       64'd200);

    // Reset right after a grant discards the held result and the pointer
    a_r[1]  = 23'h123456;
    b_r[1]  = 23'h000111;
    valid_r = 4'b0010;
    step();
    chk("rg_held", 64'(bus.res_valid), 64'd1);
    rst     = 1'b1;
    valid_r = 4'hF;
    @(negedge clk);
    chk("rg_ready_in_rst", 64'(bus.req_ready), 64'd0);
    step();
    rst = 1'b0;
    chk("rg_valid_cleared", 64'(bus.res_valid), 64'd0);
    @(negedge clk);
    chk("rg_ptr_zero", 64'(bus.req_ready), 64'(4'b0001));
    step();
    valid_r = '0;
    chk("rg_new_id", 64'(bus.res_id), 64'd0);

    // Random traffic at several injection rates with occasional reset
    for (int blk = 0; blk < 3; blk++) begin
      rate = (blk == 0) ? 25 : ((blk == 1) ? 60 : 100);
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        cons = bus.req_valid & bus.req_ready;
        step();
        rst         = ($urandom_range(0, 199) == 0);
        res_ready_r = ($urandom_range(0, 99) < 70);
        for (int k = 0; k < NREQ; k++) begin
          if (cons[k] || !valid_r[k]) begin
            valid_r[k] = ($urandom_range(0, 99) < rate);
            a_r[k]     = N'($urandom);
            b_r[k]     = N'($urandom);
          end
        end
      end
    end
    rst     = 1'b0;
    valid_r = '0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
